// File: rtl/clock_core.sv
// clock_core: 24-hour real-time clock with a two-button setup mode.
//   clock       : system clock, all logic on its rising edge
//   reset       : synchronous active-low reset
//   btn_set     : raw setup button (async, active high), steps RUN->H->M->S->RUN
//   btn_inc     : raw increment button (async, active high), bumps the selected field
//   data_ch     : running time {hour, min, sec}, binary
//   setup_data  : time being edited, same packing
//   setup_field : 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
//   sec_tick    : one-cycle pulse per elapsed second
module clock_core #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_set,
    input  logic        btn_inc,
    output logic [23:0] data_ch,
    output logic [23:0] setup_data,
    output logic [1:0]  setup_field,
    output logic        sec_tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MS_MAX   = 8'd59;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    mode_t            state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tick_nxt;
    logic [23:0]      data_nxt, setup_nxt;

    logic [1:0] set_sync, inc_sync;
    logic       set_prev, inc_prev;
    logic       set_evt, inc_evt;

    // Rising edge of the synchronised level; set wins over a coincident inc.
    assign set_evt = set_sync[1] & ~set_prev;
    assign inc_evt = inc_sync[1] & ~inc_prev & ~set_evt;

    assign setup_field = state;

    // Increment with wrap; >= keeps any field inside its legal range.
    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    // Advance one second with carries sec -> min -> hour.
    function automatic logic [23:0] next_second(input logic [23:0] t);
        logic [7:0] h, m, s;
        h = t[23:16];
        m = t[15:8];
        s = t[7:0];
        if (s >= MS_MAX) begin
            if (m >= MS_MAX) begin
                h = wrap_inc(h, HOUR_MAX);
            end
            m = wrap_inc(m, MS_MAX);
        end
        s = wrap_inc(s, MS_MAX);
        return {h, m, s};
    endfunction

    // Next-state, time and prescaler logic.
    always_comb begin
        state_nxt = state;
        data_nxt  = data_ch;
        setup_nxt = setup_data;
        cnt_nxt   = '0;
        tick_nxt  = 1'b0;

        if (state == RUN && sec_tick) begin
            data_nxt = next_second(data_ch);
        end

        case (state)
            RUN: begin
                if (set_evt) begin
                    state_nxt = SET_H;
                    setup_nxt = data_ch;
                end
            end
            SET_H: begin
                if (set_evt) begin
                    state_nxt = SET_M;
                end else if (inc_evt) begin
                    setup_nxt[23:16] = wrap_inc(setup_data[23:16], HOUR_MAX);
                end
            end
            SET_M: begin
                if (set_evt) begin
                    state_nxt = SET_S;
                end else if (inc_evt) begin
                    setup_nxt[15:8] = wrap_inc(setup_data[15:8], MS_MAX);
                end
            end
            SET_S: begin
                if (set_evt) begin
                    state_nxt = RUN;
                    data_nxt  = setup_data;
                end else if (inc_evt) begin
                    setup_nxt[7:0] = wrap_inc(setup_data[7:0], MS_MAX);
                end
            end
            default: state_nxt = RUN;
        endcase

        // Prescaler only counts while staying in RUN; any mode change restarts it.
        if (state == RUN && state_nxt == RUN) begin
            cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
        // Registered tick is high during the cycle where the count sits at CNT_MAX.
        tick_nxt = (state_nxt == RUN) && (cnt_nxt == CNT_MAX);
    end

    // State, time, prescaler and button registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= RUN;
            data_ch    <= '0;
            setup_data <= '0;
            cnt        <= '0;
            sec_tick   <= 1'b0;
            set_sync   <= '0;
            inc_sync   <= '0;
            set_prev   <= 1'b0;
            inc_prev   <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_ch    <= data_nxt;
            setup_data <= setup_nxt;
            cnt        <= cnt_nxt;
            sec_tick   <= tick_nxt;
            set_sync   <= {set_sync[0], btn_set};
            inc_sync   <= {inc_sync[0], btn_inc};
            set_prev   <= set_sync[1];
            inc_prev   <= inc_sync[1];
        end
    end

endmodule

// File: doc/clock_core.md
CLOCK_CORE -- requirements
Module: clock_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50_000_000, giving clock cycles per second (legal range 2 and up).
REQ-002 SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port btn_set, input, 1: raw level from the setup button; active high; asynchronous to clock.
REQ-005 SHALL have port btn_inc, input, 1: raw level from the increment button; active high; asynchronous to clock.
REQ-006 SHALL have port data_ch, output, 24: running time as {hour[23:16], min[15:8], sec[7:0]}, each field unsigned binary.
REQ-007 SHALL have port setup_data, output, 24: time being edited, same packing as data_ch.
REQ-008 SHALL have port setup_field, output, 2: current mode (0 RUN, 1 SET_H, 2 SET_M, 3 SET_S).
REQ-009 SHALL have port sec_tick, output, 1: one-cycle pulse each elapsed second.

Function
REQ-010 SHALL run a prescaler counting 0..CLK_DIV-1 in RUN; sec_tick SHALL be 1 for exactly the cycle in which the count equals CLK_DIV-1; the count then wraps to 0.
REQ-011 In SET_H, SET_M and SET_S, the prescaler SHALL be held at 0, sec_tick SHALL stay 0, and data_ch SHALL stay frozen.
REQ-012 On a clock edge where sec_tick=1 in RUN, data_ch SHALL advance by one second: sec 59->0 with carry to min; min 59->0 with carry to hour; hour 23->0.
REQ-013 The rollover 23:59:59 -> 00:00:00 SHALL happen in that single edge.
REQ-014 data_ch and setup_data SHALL be registered; no field SHALL ever hold a value outside hour 0..23 or min/sec 0..59.
REQ-015 Each button SHALL pass through a two-flop synchroniser, then a previous-value flop.
REQ-016 A button event SHALL be defined as synchroniser output 1 while the previous-value flop is 0, giving one event per press however long the button is held.
REQ-017 The mode or field change from a button event SHALL be visible on the 3rd rising edge after the raw button is first sampled high.
REQ-018 State transitions on a btn_set event: RUN->SET_H, SET_H->SET_M, SET_M->SET_S, SET_S->RUN; no other transitions exist.
REQ-019 On RUN->SET_H, setup_data SHALL load the current data_ch value.
REQ-020 On SET_S->RUN, data_ch SHALL load setup_data and the prescaler SHALL restart from 0, so the first sec_tick comes CLK_DIV cycles later.
REQ-021 On a btn_inc event in SET_x, only the selected field of setup_data SHALL increment, with wrap (hour 23->0; min 59->0; sec 59->0) and no carry into other fields.
REQ-022 btn_inc events in RUN SHALL be ignored.
REQ-023 If btn_set and btn_inc events occur in the same cycle, the btn_set event SHALL win and the btn_inc event SHALL be discarded.
REQ-024 In RUN, setup_data SHALL hold its last value.

Reset
REQ-025 While reset=0 at a rising edge, the following SHALL be cleared: data_ch=0, setup_data=0, setup_field=0 (RUN), sec_tick=0, prescaler=0, all synchroniser and previous-value flops=0.
REQ-026 Reset SHALL take precedence over every other event, including a pending tick, a button event, or mid-setup edits; any edits are discarded.
REQ-027 A button held high across reset release SHALL produce exactly one event, on the 3rd edge after release.

Verification (bench uses CLK_DIV=4)
REQ-028 Reset, then run 12 cycles -> sec_tick pulses on cycles 4, 8 and 12 after release; data_ch=0x000003.
REQ-029 Load 23:59:59 via setup, then let one tick elapse -> data_ch=0x000000 on the tick edge, with no intermediate value.
REQ-030 From RUN with data_ch=0x0A1E05, press btn_set then press btn_inc 15 times -> setup_field=1, setup_data hour wraps 10->23->0->1 (0x011E05); data_ch unchanged.
REQ-031 Complete the sequence set, set, inc x2 (sec 5->7), set -> setup_field=0, data_ch=0x011E07, next sec_tick exactly 4 cycles after commit.
REQ-032 btn_set and btn_inc rising in the same cycle while in SET_M -> mode becomes SET_S and setup_data is unchanged; btn_inc held 100 cycles in SET_S -> exactly one increment.
REQ-033 Assert reset while in SET_M with edited data -> setup_field=0, data_ch=0, setup_data=0 on the next edge.
